// File: rtl/smartcargo_pkg.sv
// smartcargo_pkg: shared state codes, request types and floor-field width for the car scheduler
package smartcargo_pkg;
  localparam int W_ANDAR = 2;
  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    DECIDE  = 4'd1,
    MOVENDO = 4'd2,
    PARADO  = 4'd3
  } estado_t;
  typedef enum logic [1:0] {
    CHAMADA = 2'b00,
    CANCELA = 2'b10
  } tipo_t;
endpackage

// File: rtl/escalonador_chamadas_if.sv
// escalonador_chamadas_if: request/sensor inputs and motor/debug outputs of the scheduler
interface escalonador_chamadas_if;
  import smartcargo_pkg::*;
  logic               pronto_serial;
  logic [7:0]         dados_serial;
  logic [W_ANDAR-1:0] andarAtual;
  logic               bordaSensorAtivo;
  logic               motorSubindo;
  logic               motorDescendo;
  logic [3:0]         proxParada;
  logic               temDestino;
  logic               sobe;
  logic [3:0]         db_estado;
  modport master (
    output pronto_serial, dados_serial, andarAtual, bordaSensorAtivo,
    input  motorSubindo, motorDescendo, proxParada, temDestino, sobe, db_estado
  );
  modport slave (
    input  pronto_serial, dados_serial, andarAtual, bordaSensorAtivo,
    output motorSubindo, motorDescendo, proxParada, temDestino, sobe, db_estado
  );
endinterface

// File: rtl/escalonador_chamadas_contador_parada.sv
// contador_parada: dwell counter; fim pulses on the last dwell cycle
module contador_parada #(
  parameter int T_PARADA = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic fim
);
  localparam int W = $clog2(T_PARADA + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clock) cnt <= (reset || load) ? '0 : en ? cnt + 1'b1 : cnt;
  assign fim = en && cnt == W'(T_PARADA - 1);
endmodule

// File: rtl/escalonador_chamadas.sv
// escalonador_chamadas: SCAN elevator scheduler with per-floor stops and pending destinations
module escalonador_chamadas
  import smartcargo_pkg::*;
#(
  parameter int T_PARADA  = 100,
  parameter int N_ANDARES = 4
) (
  input logic                  clock,
  input logic                  reset,
  escalonador_chamadas_if.slave bus
);
  estado_t estado, estado_n;
  logic [N_ANDARES-1:0] paradas, paradas_n;
  logic [N_ANDARES-1:0] dest_pend [N_ANDARES];
  logic [N_ANDARES-1:0] dest_pend_n [N_ANDARES];
  logic [W_ANDAR-1:0] prox, prox_n, orig, dest, alvo_ida, alvo_volta;
  logic sobe, sobe_n, chamada, cancela, serve, fim, achou_ida, achou_volta, chegou;
  logic motor_sobe, motor_desce, motor_sobe_n, motor_desce_n, tem, tem_n;
  logic unused_bits;
  // nearest pending floor strictly beyond a in the given direction
  function automatic logic [W_ANDAR:0] busca(logic [N_ANDARES-1:0] p, logic [W_ANDAR-1:0] a, logic up);
    logic [W_ANDAR:0] r;
    logic [W_ANDAR-1:0] j;
    r = '0;
    for (int i = 0; i < N_ANDARES; i++) begin
      j = W_ANDAR'(up ? i : N_ANDARES - 1 - i);
      if (!r[W_ANDAR] && p[j] && (up ? j > a : j < a)) r = {1'b1, j};
    end
    return r;
  endfunction
  always_comb begin
    chamada = bus.pronto_serial && bus.dados_serial[5:4] == CHAMADA;
    cancela = bus.pronto_serial && bus.dados_serial[5:4] == CANCELA;
    orig = bus.dados_serial[1:0];
    dest = bus.dados_serial[3:2];
    {achou_ida, alvo_ida} = busca(paradas, bus.andarAtual, sobe);
    {achou_volta, alvo_volta} = busca(paradas, bus.andarAtual, !sobe);
    chegou = bus.bordaSensorAtivo && bus.andarAtual == prox;
    estado_n = estado;
    prox_n = prox;
    sobe_n = sobe;
    case (estado)
      OCIOSO: estado_n = |paradas ? DECIDE : OCIOSO;
      DECIDE: begin
        estado_n = ~|paradas ? OCIOSO : paradas[bus.andarAtual] ? PARADO : MOVENDO;
        prox_n = achou_ida ? alvo_ida : achou_volta ? alvo_volta : prox;
        sobe_n = achou_ida || !achou_volta ? sobe : !sobe;
      end
      MOVENDO: begin
        estado_n = chegou ? PARADO : MOVENDO;
        if (chamada && (sobe ? orig > bus.andarAtual && orig < prox : orig < bus.andarAtual && orig > prox))
          prox_n = orig;
      end
      default: estado_n = fim ? DECIDE : PARADO;
    endcase
    if (cancela) estado_n = OCIOSO;
    // a call at the floor being served is absorbed into the current stop
    serve = estado_n == PARADO && (estado != PARADO || (chamada && orig == bus.andarAtual));
    paradas_n = paradas;
    dest_pend_n = dest_pend;
    if (chamada) begin
      paradas_n[orig] = 1'b1;
      if (orig != dest) dest_pend_n[orig][dest] = 1'b1;
    end
    if (serve) begin
      paradas_n = paradas_n | dest_pend_n[bus.andarAtual];
      paradas_n[bus.andarAtual] = 1'b0;
      dest_pend_n[bus.andarAtual] = '0;
    end
    if (cancela) begin
      paradas_n = '0;
      dest_pend_n = '{default: '0};
    end
    tem_n = |paradas_n;
    for (int i = 0; i < N_ANDARES; i++) tem_n = tem_n | (|dest_pend_n[i]);
    tem_n = tem_n && estado_n != OCIOSO;
    motor_sobe_n = estado_n == MOVENDO && prox_n > bus.andarAtual;
    motor_desce_n = estado_n == MOVENDO && prox_n < bus.andarAtual;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      paradas <= '0;
      dest_pend <= '{default: '0};
      prox <= '0;
      sobe <= 1'b1;
      motor_sobe <= 1'b0;
      motor_desce <= 1'b0;
      tem <= 1'b0;
    end else begin
      estado <= estado_n;
      paradas <= paradas_n;
      dest_pend <= dest_pend_n;
      prox <= prox_n;
      sobe <= sobe_n;
      motor_sobe <= motor_sobe_n;
      motor_desce <= motor_desce_n;
      tem <= tem_n;
    end
  end
  contador_parada #(.T_PARADA(T_PARADA)) u_contador (
    .clock(clock),
    .reset(reset),
    .load (serve),
    .en   (estado == PARADO),
    .fim  (fim)
  );
  assign unused_bits = ^bus.dados_serial[7:6];
  assign bus.motorSubindo = motor_sobe;
  assign bus.motorDescendo = motor_desce;
  assign bus.proxParada = 4'(prox);
  assign bus.temDestino = tem;
  assign bus.sobe = sobe;
  assign bus.db_estado = estado;
endmodule

// File: tb/tb_escalonador_chamadas.sv
// tb_escalonador_chamadas: directed scenarios for the scheduler with a short dwell time
module tb_escalonador_chamadas;
  import smartcargo_pkg::*;
  localparam int T = 4;
  localparam logic [1:0] M0 = 2'b00, UP = 2'b10, DN = 2'b01;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  escalonador_chamadas_if bus ();
  escalonador_chamadas #(.T_PARADA(T), .N_ANDARES(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic st(string tag, logic [3:0] e, logic [1:0] m, logic t);
    chk({tag, ":estado"}, bus.db_estado, e);
    chk({tag, ":motor"}, {2'b00, bus.motorSubindo, bus.motorDescendo}, {2'b00, m});
    chk({tag, ":tem"}, {3'b000, bus.temDestino}, {3'b000, t});
  endtask
  task automatic px(string tag, logic [3:0] p, logic s);
    chk({tag, ":prox"}, bus.proxParada, p);
    chk({tag, ":sobe"}, {3'b000, bus.sobe}, {3'b000, s});
  endtask
  task automatic send(logic [7:0] d);
    bus.pronto_serial = 1'b1;
    bus.dados_serial = d;
    tick();
    bus.pronto_serial = 1'b0;
  endtask
  task automatic arrive(logic [1:0] f);
    bus.andarAtual = f;
    bus.bordaSensorAtivo = 1'b1;
    tick();
    bus.bordaSensorAtivo = 1'b0;
  endtask
  // motors are mutually exclusive and only ever driven while moving
  always @(negedge clock) begin
    if (!reset) begin
      vectors++;
      assert (!(bus.motorSubindo && bus.motorDescendo) &&
              (bus.db_estado == MOVENDO || !(bus.motorSubindo || bus.motorDescendo)))
      else begin
        miscompares++;
        $error("FAIL motor_guard su=%b de=%b estado=%0d", bus.motorSubindo, bus.motorDescendo, bus.db_estado);
      end
    end
  end
  initial begin
    bus.pronto_serial = 1'b0;
    bus.dados_serial = '0;
    bus.andarAtual = 2'd0;
    bus.bordaSensorAtivo = 1'b0;
    tick(2);
    reset = 1'b0;
    st("rst", OCIOSO, M0, 1'b0);
    px("rst", 4'd0, 1'b1);
    // call 0->3 with the car at 0: dwell at 0, then climb to 3
    send(8'h0C);
    st("s1_req", OCIOSO, M0, 1'b0);
    tick();
    st("s1_dec", DECIDE, M0, 1'b1);
    tick();
    st("s1_stop0", PARADO, M0, 1'b1);
    tick(3);
    st("s1_dwell", PARADO, M0, 1'b1);
    tick();
    st("s1_dec2", DECIDE, M0, 1'b1);
    tick();
    st("s1_move", MOVENDO, UP, 1'b1);
    px("s1_move", 4'd3, 1'b1);
    arrive(2'd1);
    arrive(2'd2);
    st("s1_pass2", MOVENDO, UP, 1'b1);
    arrive(2'd3);
    st("s1_stop3", PARADO, M0, 1'b0);
    tick(5);
    st("s1_idle", OCIOSO, M0, 1'b0);
    // moving 0->3, call 1->2 picked up on the way
    reset = 1'b1;
    bus.andarAtual = 2'd0;
    tick();
    reset = 1'b0;
    send(8'h0F);
    tick(2);
    st("s2_lat", MOVENDO, UP, 1'b1);
    px("s2_lat", 4'd3, 1'b1);
    send(8'h09);
    px("s2_pick", 4'd1, 1'b1);
    arrive(2'd1);
    st("s2_stop1", PARADO, M0, 1'b1);
    tick(4);
    st("s2_dec", DECIDE, M0, 1'b1);
    tick();
    px("s2_to2", 4'd2, 1'b1);
    arrive(2'd2);
    st("s2_stop2", PARADO, M0, 1'b1);
    tick(5);
    st("s2_to3", MOVENDO, UP, 1'b1);
    px("s2_to3", 4'd3, 1'b1);
    arrive(2'd3);
    st("s2_stop3", PARADO, M0, 1'b0);
    tick(5);
    st("s2_idle", OCIOSO, M0, 1'b0);
    // at 2 heading to 3, call 0->1 behind: serve 3, reverse, 0, then 1
    reset = 1'b1;
    bus.andarAtual = 2'd2;
    tick();
    reset = 1'b0;
    send(8'h0F);
    tick(2);
    send(8'h04);
    px("s3_nopick", 4'd3, 1'b1);
    st("s3_nopick", MOVENDO, UP, 1'b1);
    arrive(2'd3);
    st("s3_stop3", PARADO, M0, 1'b1);
    tick(5);
    st("s3_down", MOVENDO, DN, 1'b1);
    px("s3_down", 4'd0, 1'b0);
    arrive(2'd2);
    arrive(2'd1);
    st("s3_pass1", MOVENDO, DN, 1'b1);
    arrive(2'd0);
    st("s3_stop0", PARADO, M0, 1'b1);
    tick(5);
    st("s3_up", MOVENDO, UP, 1'b1);
    px("s3_up", 4'd1, 1'b1);
    arrive(2'd1);
    st("s3_stop1", PARADO, M0, 1'b0);
    tick(5);
    st("s3_idle", OCIOSO, M0, 1'b0);
    // at 1: call 1->1 then 2->0 twice, one stop per floor
    send(8'h05);
    st("s4_a", OCIOSO, M0, 1'b0);
    send(8'h02);
    st("s4_b", DECIDE, M0, 1'b1);
    send(8'h02);
    st("s4_stop1", PARADO, M0, 1'b1);
    tick(4);
    st("s4_dec", DECIDE, M0, 1'b1);
    tick();
    px("s4_to2", 4'd2, 1'b1);
    arrive(2'd2);
    st("s4_stop2", PARADO, M0, 1'b1);
    tick(5);
    st("s4_down", MOVENDO, DN, 1'b1);
    px("s4_down", 4'd0, 1'b0);
    arrive(2'd1);
    st("s4_pass1", MOVENDO, DN, 1'b1);
    arrive(2'd0);
    st("s4_stop0", PARADO, M0, 1'b0);
    tick(5);
    st("s4_idle", OCIOSO, M0, 1'b0);
    // cancel while moving, then reset mid-dwell
    send(8'h0F);
    tick(2);
    st("s5_move", MOVENDO, UP, 1'b1);
    px("s5_move", 4'd3, 1'b1);
    send(8'h20);
    st("s5_cancel", OCIOSO, M0, 1'b0);
    tick();
    st("s5_cancel2", OCIOSO, M0, 1'b0);
    send(8'h0C);
    tick(2);
    st("s5_dwell", PARADO, M0, 1'b1);
    reset = 1'b1;
    tick();
    st("s5_rst", OCIOSO, M0, 1'b0);
    px("s5_rst", 4'd0, 1'b1);
    bus.pronto_serial = 1'b1;
    bus.dados_serial = 8'h0C;
    bus.bordaSensorAtivo = 1'b1;
    tick();
    bus.pronto_serial = 1'b0;
    bus.bordaSensorAtivo = 1'b0;
    reset = 1'b0;
    st("s5_rstprio", OCIOSO, M0, 1'b0);
    tick();
    st("s5_rstprio2", OCIOSO, M0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/escalonador_chamadas.md
ESCALONADOR_CHAMADAS -- requirements
Module: escalonador_chamadas

Interface
REQ-001 Parameter T_PARADA, default 100, clock cycles the car dwells at a served floor.
REQ-002 Parameter N_ANDARES, default 4, number of floors (0..3); floor fields are 2 bits.
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pronto_serial  in  1  one-cycle pulse: dados_serial holds a new request.
REQ-006 dados_serial  in  8  [1:0] origin, [3:2] destination, [5:4] type, [7:6] ignored.
REQ-007 andarAtual  in  2  floor at which the car currently sits, from the sensor decoder.
REQ-008 bordaSensorAtivo  in  1  one-cycle pulse when a floor sensor becomes active.
REQ-009 motorSubindo / motorDescendo  out  1 each  motor drive commands, never both high.
REQ-010 proxParada  out  4  next target floor, zero-extended.
REQ-011 temDestino  out  1  high while any stop is pending.
REQ-012 sobe  out  1  current scan direction (1 = up).
REQ-013 db_estado  out  4  FSM state code for 7-segment debug.

Function
REQ-014 Type 2'b00 = call: sets paradas[origin] and destPend[origin][destination]; type 2'b10 = cancel all: clears paradas and destPend; 2'b01/2'b11 ignored.
REQ-015 Requests are idempotent (bitwise OR); origin == destination registers only the origin stop.
REQ-016 FSM states: OCIOSO, DECIDE, MOVENDO, PARADO; encoding fixed in the package.
REQ-017 OCIOSO: motors off; temDestino low; goes to DECIDE the cycle after paradas becomes non-zero.
REQ-018 DECIDE (one cycle): if paradas[andarAtual] then PARADO; else proxParada = nearest pending floor in direction sobe; if none that way, sobe toggles and the nearest floor the other way is chosen; then MOVENDO; if paradas is empty, OCIOSO.
REQ-019 MOVENDO: motorSubindo = (proxParada > andarAtual), motorDescendo = (proxParada < andarAtual); on bordaSensorAtivo with andarAtual == proxParada go to PARADO, motors off in that same transition edge.
REQ-020 A new call lying between andarAtual and proxParada in the travel direction replaces proxParada on the next cycle (SCAN pickup).
REQ-021 PARADO entry: paradas[f] cleared, paradas |= destPend[f], destPend[f] cleared, f = andarAtual; dwell counter loads 0.
REQ-022 PARADO: motors off; after T_PARADA cycles go to DECIDE.
REQ-023 A call whose origin is f during PARADO at f: destination merged into paradas, dwell counter restarts, paradas[f] stays clear.
REQ-024 Call and arrival in the same cycle at the same floor: served by this stop, bit ends clear.
REQ-025 Cancel type in any state: next state OCIOSO, motors off next edge.
REQ-026 Latency: pronto_serial at cycle n in OCIOSO -> DECIDE at n+2, motor command at n+3.
REQ-027 temDestino = |paradas or |destPend, registered.

Reset
REQ-028 Reset at any state, including MOVENDO: next edge state OCIOSO, paradas = 0, destPend = 0, proxParada = 0, sobe = 1, motors 0, temDestino 0, dwell counter 0, db_estado = OCIOSO code.
REQ-029 Reset has priority over pronto_serial and bordaSensorAtivo in the same cycle.

Structure
REQ-030 Package smartcargo_pkg holds state codes, type codes (CHAMADA, CANCELA) and the floor-field width.
REQ-031 Dwell timing in one sub-module contador_parada (load, count, fim pulse at T_PARADA-1).
REQ-032 Next-floor search is combinational inside the block; no other sub-modules.

Verification
REQ-033 Reset; car at 0; call 0->3 -> PARADO at 0 for T_PARADA cycles, then motorSubindo, proxParada 3, stops at 3, OCIOSO, temDestino 0.
REQ-034 Car moving 0->3, call 1->2 arrives before floor 1 -> proxParada changes to 1, stops at 1, then 2, then 3.
REQ-035 Car at 2 going up to 3, call 0->1 -> serves 3, sobe toggles to 0, then 0, then 1.
REQ-036 Duplicate call 2->0 sent twice, plus call 1->1 -> single stop each; origin==destination adds no extra stop.
REQ-037 Cancel (type 2'b10) while MOVENDO -> motors 0 next edge, OCIOSO, temDestino 0; reset mid-PARADO -> all outputs at reset values next edge.
REQ-038 Every cycle: motorSubindo and motorDescendo never simultaneously 1; motors 0 outside MOVENDO.
